// File: rtl/ram_pipe_if.sv
// Request/response bundle between the MEM stage and ram_pipe.
// RAM_PARITY_EN adds the per-byte parity error vector.
interface ram_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    localparam int NB = DATA_W / 8;

    logic              we;
    logic [NB-1:0]     wbe;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              clear_req;
    logic              busy;

`ifdef RAM_PARITY_EN
    logic [NB-1:0]     perr;

    modport master (
        output we, wbe, waddr, wdata, re, raddr, clear_req,
        input  rdata, rvalid, busy, perr
    );
    modport slave (
        input  we, wbe, waddr, wdata, re, raddr, clear_req,
        output rdata, rvalid, busy, perr
    );
`else
    modport master (
        output we, wbe, waddr, wdata, re, raddr, clear_req,
        input  rdata, rvalid, busy
    );
    modport slave (
        input  we, wbe, waddr, wdata, re, raddr, clear_req,
        output rdata, rvalid, busy
    );
`endif
endinterface

// File: rtl/ram_pipe.sv
// 1W/1R synchronous RAM with byte enables, 1- or 2-cycle read pipeline and a zero-fill clear engine.
// Define RAM_PARITY_EN to store an even-parity bit per byte and report mismatches on perr.
module ram_pipe #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 1
) (
    input  logic     clk,
    input  logic     reset,
    ram_pipe_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             busy;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic             accept_ok, wr_acc, rd_acc;
    logic             w_in_range, r_in_range;
    logic [IDX_W-1:0] waddr_idx, raddr_idx;
    logic [NB-1:0]    byp;
    logic [DATA_W-1:0] rd_word;

    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q;

    // ------------------------------------------------------------------
    // Clear FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                if (bus.clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        case (state_q)
            ST_CLEAR: busy = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

    assign bus.busy = busy;

    // ------------------------------------------------------------------
    // Request acceptance: a clear request in IDLE drops that cycle's access
    // ------------------------------------------------------------------
    assign accept_ok  = !reset && (state_q == ST_IDLE) && !bus.clear_req;
    assign w_in_range = {1'b0, bus.waddr} < DEPTH_A;
    assign r_in_range = {1'b0, bus.raddr} < DEPTH_A;
    assign waddr_idx  = bus.waddr[IDX_W-1:0];
    assign raddr_idx  = bus.raddr[IDX_W-1:0];
    assign wr_acc     = bus.we && accept_ok && w_in_range;
    assign rd_acc     = bus.re && accept_ok;

    // NOTE: the array has no reset branch; the clear engine zero-fills it, so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wbe[i]) mem_q[waddr_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    // Write-first: enabled bytes of a same-address write bypass the array.
    always_comb begin
        byp = '0;
        for (int i = 0; i < NB; i++) begin
            byp[i] = wr_acc && (bus.waddr == bus.raddr) && bus.wbe[i];
        end
    end

    always_comb begin
        rd_word = '0;
        if (r_in_range) begin
            rd_word = mem_q[raddr_idx];
            for (int i = 0; i < NB; i++) begin
                if (byp[i]) rd_word[8*i +: 8] = bus.wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_acc;
            if (rd_acc) s1_data_q <= rd_word;
        end
    end

`ifdef RAM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] perr_word;
    logic [NB-1:0] s1_perr_q;

    always_ff @(posedge clk) begin
        if (busy) begin
            par_q[cnt_q] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wbe[i]) par_q[waddr_idx][i] <= ^bus.wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        perr_word = '0;
        if (r_in_range) begin
            for (int i = 0; i < NB; i++) begin
                perr_word[i] = !byp[i] &&
                               (par_q[raddr_idx][i] != ^mem_q[raddr_idx][8*i +: 8]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) s1_perr_q <= '0;
        else       s1_perr_q <= rd_acc ? perr_word : '0;
    end
`endif

    // ------------------------------------------------------------------
    // Output stage selection
    // ------------------------------------------------------------------
    if (READ_LAT == 2) begin : g_lat2
        logic              s2_valid_q;
        logic [DATA_W-1:0] s2_data_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) s2_data_q <= s1_data_q;
            end
        end

        assign bus.rvalid = s2_valid_q;
        assign bus.rdata  = s2_data_q;

`ifdef RAM_PARITY_EN
        logic [NB-1:0] s2_perr_q;

        always_ff @(posedge clk) begin
            if (reset) s2_perr_q <= '0;
            else       s2_perr_q <= s1_valid_q ? s1_perr_q : '0;
        end

        assign bus.perr = s2_perr_q;
`endif
    end else begin : g_lat1
        assign bus.rvalid = s1_valid_q;
        assign bus.rdata  = s1_data_q;
`ifdef RAM_PARITY_EN
        assign bus.perr   = s1_perr_q;
`endif
    end

endmodule

// File: tb/tb_ram_pipe.sv
// Self-checking bench: one READ_LAT=1 and one READ_LAT=2 instance share stimulus and are
// compared every cycle against a queue/array reference model, plus a fixed vector table.
module tb_ram_pipe;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 256;
    localparam int NB     = DATA_W / 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();
    ram_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus2 ();

    assign bus2.we        = bus1.we;
    assign bus2.wbe       = bus1.wbe;
    assign bus2.waddr     = bus1.waddr;
    assign bus2.wdata     = bus1.wdata;
    assign bus2.re        = bus1.re;
    assign bus2.raddr     = bus1.raddr;
    assign bus2.clear_req = bus1.clear_req;

    ram_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    ram_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: word array, remaining clear cycles, and in-flight reads with due cycles.
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                clear_left;
    logic [DATA_W-1:0] q1_d[$], q2_d[$];
    int                q1_t[$], q2_t[$];
    logic [DATA_W-1:0] e1_rdata, e2_rdata;

    typedef struct packed {
        logic              we;
        logic [NB-1:0]     wbe;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic              re;
        logic [ADDR_W-1:0] raddr;
        logic              e1_v;
        logic [DATA_W-1:0] e1_d;
        logic              e2_v;
        logic [DATA_W-1:0] e2_d;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic we, input logic [NB-1:0] wbe, input logic [ADDR_W-1:0] waddr,
                         input logic [DATA_W-1:0] wdata, input logic re,
                         input logic [ADDR_W-1:0] raddr, input logic clr);
        bus1.we        = we;
        bus1.wbe       = wbe;
        bus1.waddr     = waddr;
        bus1.wdata     = wdata;
        bus1.re        = re;
        bus1.raddr     = raddr;
        bus1.clear_req = clr;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic zero_model();
        foreach (m_mem[i]) m_mem[i] = '0;
    endtask

    function automatic logic [DATA_W-1:0] model_read();
        logic [DATA_W-1:0] v;
        v = '0;
        if (int'(bus1.raddr) < DEPTH) begin
            v = m_mem[bus1.raddr[7:0]];
            if (bus1.we && bus1.waddr == bus1.raddr) begin
                for (int i = 0; i < NB; i++)
                    if (bus1.wbe[i]) v[8*i +: 8] = bus1.wdata[8*i +: 8];
            end
        end
        return v;
    endfunction

    // Predicts the effect of the coming edge, advances one clock, then compares both DUTs.
    task automatic tick();
        logic exp_v1, exp_v2;
        if (reset) begin
            clear_left = DEPTH;
            zero_model();
            q1_d.delete(); q1_t.delete(); q2_d.delete(); q2_t.delete();
            e1_rdata = '0;
            e2_rdata = '0;
        end else if (clear_left > 0) begin
            clear_left--;
        end else if (bus1.clear_req) begin
            clear_left = DEPTH;
            zero_model();
        end else begin
            if (bus1.re) begin
                q1_d.push_back(model_read()); q1_t.push_back(cyc + 1);
                q2_d.push_back(model_read()); q2_t.push_back(cyc + 2);
            end
            if (bus1.we && int'(bus1.waddr) < DEPTH) begin
                for (int i = 0; i < NB; i++)
                    if (bus1.wbe[i]) m_mem[bus1.waddr[7:0]][8*i +: 8] = bus1.wdata[8*i +: 8];
            end
        end

        @(posedge clk);
        #1;
        cyc++;

        exp_v1 = (q1_t.size() > 0) && (q1_t[0] == cyc);
        if (exp_v1) begin
            e1_rdata = q1_d.pop_front();
            void'(q1_t.pop_front());
        end
        exp_v2 = (q2_t.size() > 0) && (q2_t[0] == cyc);
        if (exp_v2) begin
            e2_rdata = q2_d.pop_front();
            void'(q2_t.pop_front());
        end

        check("model_busy1",   32'(bus1.busy),   32'(clear_left > 0));
        check("model_busy2",   32'(bus2.busy),   32'(clear_left > 0));
        check("model_rvalid1", 32'(bus1.rvalid), 32'(exp_v1));
        check("model_rdata1",  bus1.rdata,       e1_rdata);
        check("model_rvalid2", 32'(bus2.rvalid), 32'(exp_v2));
        check("model_rdata2",  bus2.rdata,       e2_rdata);
    endtask

    // Counts cycles with busy high; bounded so a stuck clear still terminates.
    task automatic count_busy(output int n);
        n = 0;
        while (bus1.busy === 1'b1 && n < 4 * DEPTH) begin
            tick();
            n++;
        end
    endtask

    task automatic add(input logic we, input logic [NB-1:0] wbe, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] wd, input logic re, input logic [ADDR_W-1:0] ra,
                       input logic e1v, input logic [DATA_W-1:0] e1d,
                       input logic e2v, input logic [DATA_W-1:0] e2d);
        vt.push_back('{we, wbe, wa, wd, re, ra, e1v, e1d, e2v, e2d});
    endtask

    initial begin
        int n;

        // Expected values: DUT outputs one edge after each row (lat1) and lat2 one row later.
        add(0, 4'h0,   0, 32'h0,        1,   0, 1, 32'h0,        0, 32'h0);
        add(0, 4'h0,   0, 32'h0,        1, 127, 1, 32'h0,        1, 32'h0);
        add(0, 4'h0,   0, 32'h0,        1, 255, 1, 32'h0,        1, 32'h0);
        add(0, 4'h0,   0, 32'h0,        1, 300, 1, 32'h0,        1, 32'h0);
        add(1, 4'hF,   5, 32'hDEADBEEF, 0,   0, 0, 32'h0,        1, 32'h0);
        add(1, 4'h5,   5, 32'h11223344, 0,   0, 0, 32'h0,        0, 32'h0);
        add(0, 4'h0,   0, 32'h0,        1,   5, 1, 32'hDE22BE44, 0, 32'h0);
        add(1, 4'hF,   9, 32'h12345678, 0,   0, 0, 32'hDE22BE44, 1, 32'hDE22BE44);
        add(1, 4'h3,   9, 32'hCAFEF00D, 1,   9, 1, 32'h1234F00D, 0, 32'hDE22BE44);
        add(0, 4'h0,   0, 32'h0,        1,   9, 1, 32'h1234F00D, 1, 32'h1234F00D);
        add(1, 4'hF, 300, 32'hFFFFFFFF, 0,   0, 0, 32'h1234F00D, 1, 32'h1234F00D);
        add(0, 4'h0,   0, 32'h0,        1, 300, 1, 32'h0,        0, 32'h1234F00D);
        add(0, 4'h0,   0, 32'h0,        1,  44, 1, 32'h0,        1, 32'h0);
        add(1, 4'hF,   1, 32'h0000000A, 0,   0, 0, 32'h0,        1, 32'h0);
        add(1, 4'hF,   2, 32'h0000000B, 0,   0, 0, 32'h0,        0, 32'h0);
        add(1, 4'hF,   3, 32'h0000000C, 0,   0, 0, 32'h0,        0, 32'h0);
        add(0, 4'h0,   0, 32'h0,        1,   1, 1, 32'h0000000A, 0, 32'h0);
        add(0, 4'h0,   0, 32'h0,        1,   2, 1, 32'h0000000B, 1, 32'h0000000A);
        add(0, 4'h0,   0, 32'h0,        1,   3, 1, 32'h0000000C, 1, 32'h0000000B);
        add(0, 4'h0,   0, 32'h0,        0,   0, 0, 32'h0000000C, 1, 32'h0000000C);
        add(0, 4'h0,   0, 32'h0,        0,   0, 0, 32'h0000000C, 0, 32'h0000000C);

        // Reset and initial clear
        idle();
        reset = 1'b1;
        tick();
        tick();
        check("reset_rvalid", 32'(bus1.rvalid), 32'd0);
        check("reset_rdata",  bus1.rdata,       32'd0);
        check("reset_busy",   32'(bus1.busy),   32'd1);
        reset = 1'b0;
        count_busy(n);
        check("init_clear_cycles", n, DEPTH);

        // Vector table
        foreach (vt[i]) begin
            drive(vt[i].we, vt[i].wbe, vt[i].waddr, vt[i].wdata, vt[i].re, vt[i].raddr, 1'b0);
            tick();
            check($sformatf("vec%0d_rvalid1", i), 32'(bus1.rvalid), 32'(vt[i].e1_v));
            check($sformatf("vec%0d_rdata1", i),  bus1.rdata,       vt[i].e1_d);
            check($sformatf("vec%0d_rvalid2", i), 32'(bus2.rvalid), 32'(vt[i].e2_v));
            check($sformatf("vec%0d_rdata2", i),  bus2.rdata,       vt[i].e2_d);
        end

        // Read just before clear completes; clear drops the same-cycle write and read
        drive(1, 4'hF, 3, 32'h00000077, 0, 0, 0);
        tick();
        drive(0, 4'h0, 0, 32'h0, 1, 3, 0);
        tick();
        drive(1, 4'hF, 3, 32'h00000055, 1, 3, 1);
        tick();
        check("clr_read_dropped", 32'(bus1.rvalid), 32'd0);
        check("clr_prior_rvalid2", 32'(bus2.rvalid), 32'd1);
        check("clr_prior_rdata2",  bus2.rdata,       32'h00000077);
        idle();
        count_busy(n);
        check("req_clear_cycles", n, DEPTH);
        drive(0, 4'h0, 0, 32'h0, 1, 3, 0);
        tick();
        check("after_clear_rvalid", 32'(bus1.rvalid), 32'd1);
        check("after_clear_rdata",  bus1.rdata,       32'd0);
        idle();
        tick();

        // Reset at cycle 100 of a clear restarts it
        drive(0, 4'h0, 0, 32'h0, 0, 0, 1);
        tick();
        idle();
        repeat (99) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy(n);
        check("reset_mid_clear_cycles", n, DEPTH);

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            int r;
            r = int'($urandom_range(0, 2999));
            bus1.we        = 1'($urandom_range(0, 1));
            bus1.wbe       = 4'($urandom);
            bus1.waddr     = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(250, 511))
                                                         : 9'($urandom_range(0, 15));
            bus1.wdata     = $urandom;
            bus1.re        = 1'($urandom_range(0, 1));
            bus1.raddr     = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(250, 511))
                                                         : 9'($urandom_range(0, 15));
            bus1.clear_req = (r < 2);
            reset          = (r == 2999);
            tick();
        end
        reset = 1'b0;
        idle();
        count_busy(n);

        // Reset while a READ_LAT=2 read is in flight flushes it
        drive(0, 4'h0, 0, 32'h0, 1, 5, 0);
        tick();
        idle();
        reset = 1'b1;
        tick();
        check("flush_rvalid2", 32'(bus2.rvalid), 32'd0);
        check("flush_rdata2",  bus2.rdata,       32'd0);
        reset = 1'b0;
        count_busy(n);
        check("flush_clear_cycles", n, DEPTH);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_pipe.md
Name: ram_pipe

Overview:
- Parametrised successor to the core's single-port behavioural data memory.
- Synchronous 1-write/1-read RAM with:
  - configurable width, depth and read latency
  - per-byte write enables
  - a valid-qualified read pipeline
  - a hardware clear engine that zero-fills the array after reset or on request
- Sits behind the MEM stage of the 5-stage pipeline; `busy` stalls the pipeline while the clear engine runs.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of words; must be ≤ 2^ADDR_W.
- READ_LAT, 1, read latency in cycles; legal values are 1 or 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- we  in  1  write enable
- wbe  in  DATA_W/8  byte enables; bit i covers wdata[8i+7:8i]
- waddr  in  ADDR_W  write word address
- wdata  in  DATA_W  write data
- re  in  1  read request
- raddr  in  ADDR_W  read word address
- rdata  out  DATA_W  read data
- rvalid  out  1  rdata valid, single-cycle pulse per accepted read
- clear_req  in  1  request a full zero-fill
- busy  out  1  clear engine active; all requests ignored

Behaviour:
- Single clock domain (clk); reset is synchronous and active-high.
- Reset values: rdata=0, rvalid=0, busy=1; FSM=CLEAR; clear counter=0; read pipeline valid bits=0.
- Reset asserted mid-clear or mid-read restarts the clear from address 0 and flushes in-flight reads.
- FSM has two states: CLEAR and IDLE.
  - CLEAR: writes 0 to address `cnt` each cycle. When cnt==DEPTH-1 the FSM goes to IDLE and busy falls the next cycle. A clear therefore takes exactly DEPTH cycles.
  - IDLE: when clear_req=1, the FSM goes to CLEAR with cnt=0 and busy=1 from the next cycle.
- While busy=1: we, re and clear_req are ignored, and no new rvalid is generated.
- Same cycle as clear_req in IDLE: clear takes priority; the write and the read in that cycle are dropped.
- Write: accepted at posedge when we=1 and busy=0. Only bytes with wbe[i]=1 are updated. we=1 with wbe=0 is a no-op.
- Read: accepted at posedge when re=1 and busy=0.
  - READ_LAT=1: rdata and rvalid update at the same edge that samples re, i.e. they are visible in the following cycle.
  - READ_LAT=2: one extra register stage.
- Array data is captured at acceptance. A later write to the same address cannot alter a read already in flight.
- A read accepted in the cycle before clear entry completes normally.
- Same-cycle write and read to the same address returns new data (write-first): bytes with wbe=1 come from wdata, the rest from the array.
- Out-of-range addresses (addr ≥ DEPTH):
  - writes are dropped;
  - reads return all-zero data with rvalid=1.
- rdata holds its last value while rvalid=0.
- Back-to-back reads: one accepted per cycle, full throughput, in-order returns.
- X/Z on we or re: no write occurs, the read is treated as not accepted, and the array is not modified. The array is never wiped on X; only CLEAR zero-fills.

Optional Feature:
- Macro: RAM_PARITY_EN.
- When defined:
  - each byte stores an even-parity bit, computed on write and written as 0 during CLEAR (a zero byte has parity 0);
  - an extra output `perr` (DATA_W/8 bits) is aligned with rvalid; bit i=1 marks a parity mismatch on byte i;
  - reset value of perr is 0;
  - perr is 0 whenever rvalid=0;
  - write-first bypass bytes use freshly computed parity and so never flag.
- When undefined: no parity storage and no perr port.

Test Plan:
- Reset with DEPTH=256 → busy=1 for exactly 256 cycles after reset deasserts. Then read addresses 0, 127 and 255 → rdata=0x00000000, rvalid=1.
- Write 0xDEADBEEF to address 5 with wbe=4'b1111, then write 0x11223344 to address 5 with wbe=4'b0101 → read of address 5 returns 0xDE22BE44.
- READ_LAT=2: issue re at addresses 1, 2 and 3 on consecutive cycles (memory preloaded with 0xA, 0xB, 0xC) → rvalid high for 3 consecutive cycles starting 2 cycles later, with rdata 0xA, 0xB, 0xC in order.
- Same cycle: write 0xCAFEF00D to address 9 with wbe=4'b0011 (address 9 holds 0x12345678) plus a read of address 9 → rdata=0x1234F00D.
- clear_req together with a write of address 3 after data has been written → the write is dropped, busy=1 for DEPTH cycles, and a subsequent read of address 3 returns 0.
- Assert reset at cycle 100 of a clear → busy stays 1 for a further DEPTH cycles counted from reset deassertion.
- Read of address 300 with DEPTH=256 → rvalid=1, rdata=0.
